prbs_burst_ctrl: RTL and testbench
==================================

Name: prbs_burst_ctrl

Overview:
Shares one 8-bit Fibonacci LFSR pseudonoise engine between NREQ requesters. Each requester wins a round-robin grant and receives a burst of BURST_BYTES bytes generated with its own seed and tap polynomial. Output is byte-wide with a valid/ready handshake. The block sits between test-pattern consumers and the shared generator datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
BURST_BYTES, 4, bytes emitted per grant (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset
req  in  NREQ  per-requester burst request, level
seed  in  8*NREQ  per-requester seed; slice i = seed[8i+7:8i]
poly_sel  in  2*NREQ  per-requester tap select; slice i = poly_sel[2i+1:2i]
grant  out  NREQ  one-hot; held for the whole burst
done  out  NREQ  1-cycle pulse to the granted requester at burst end
out_byte  out  8  generated byte, first bit in MSB
out_valid  out  1  out_byte valid
out_ready  in  1  consumer accepts out_byte
busy  out  1  state != IDLE

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high.
- Reset values: grant=0, done=0, out_byte=8'h00, out_valid=0, busy=0, FSM=IDLE, round-robin pointer=0, lfsr=8'hFF, bit_cnt=0, byte_cnt=0.
- Tap table, poly_sel -> mask: 0:8'hB8, 1:8'hB4, 2:8'hB2, 3:8'hE1 (all maximal-length).
- LFSR step: out bit = lfsr[7]; lfsr <= {lfsr[6:0], ^(lfsr & mask)}.
- FSM: IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: if any req is high, pick the first requester at or after the pointer (circular). Register grant. Go to LOAD. Pointer <= winner+1 mod NREQ.
  - LOAD, 1 cycle: lfsr <= winner seed, or 8'hFF if seed==0 (lock-up guard). Latch mask. bit_cnt=0, byte_cnt=0.
  - RUN: each non-stalled cycle, step the LFSR and shift the out bit into the assembler. bit_cnt increments.
    - When bit_cnt==7: out_byte <= {asm[6:0], lfsr[7]}, out_valid <= 1, byte_cnt++.
    - Stall (LFSR and assembler hold) only when bit_cnt==7 && out_valid && !out_ready.
    - When the BURST_BYTES-th byte is loaded, go to DRAIN.
  - DRAIN: wait for out_valid && out_ready, then go to DONE.
  - DONE, 1 cycle: done[winner]=1, grant <= 0. Go to IDLE.
- out_valid clears on an out_ready handshake unless a new byte loads in the same cycle; a new byte has priority.
- Latency: req high in IDLE at cycle T -> grant at T+1 -> first out_valid at T+10. Unstalled rate is 1 byte per 8 cycles.
- req is sampled only in IDLE. Dropping req mid-burst does not abort; the burst completes. A winner whose req stays high may win again next arbitration only if no other requester is pending.
- Reset asserted mid-burst: everything returns to reset values immediately; no done pulse.

Optional Feature:
PRBS_CTRL_RESUME_EN
- Defined: a per-requester 8-bit state store (reset 8'hFF) receives the LFSR state in DONE. In LOAD the LFSR loads the stored state instead of seed, so each requester continues its own sequence across grants. seed is then used only on the first grant after reset.
- Undefined: no store; every grant reseeds from seed.

Decomposition:
- Package prbs_pkg: typedef of FSM states (IDLE, LOAD, RUN, DRAIN, DONE); POLY_SEL_W=2; the 4-entry tap mask constant array; SEED_LOCKUP_FIX=8'hFF.
- Sub-module rr_arbiter (parameter N): combinational request vector + pointer -> one-hot winner and index. The LFSR step stays inline.

Test Plan:
- Reset, then req=4'b0001, seed0=8'hFF, poly_sel0=0, out_ready=1 -> grant=0001 at T+1; bytes 8'hFF, 8'h0B, ...; 4 bytes, then done[0] pulse, grant=0.
- req=4'b1111 held -> grants in order 0,1,2,3,0; no requester starved; exactly 4 bytes per grant.
- seed2=8'h00 -> output identical to seed 8'hFF with the same poly_sel.
- Hold out_ready=0 after the first byte -> LFSR frozen at bit_cnt==7; out_byte stable. Release -> sequence continues with no bit lost or duplicated (compare against a reference model).
- rst pulse while in RUN with byte_cnt=2 -> immediate return to reset values; no done pulse; the next grant restarts from the seed.
- With PRBS_CTRL_RESUME_EN, two grants to requester 1 -> the second grant's first byte equals the byte that would follow the first grant's 4th byte.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types and constants for the prbs_burst_ctrl slice.
// Holds the FSM state encoding, the tap-mask table and the LFSR step helper.
package prbs_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int POLY_SEL_W = 2;

  // All four masks give maximal-length 8-bit sequences.
  localparam logic [7:0] TAP_MASK [4] = '{8'hB8, 8'hB4, 8'hB2, 8'hE1};

  localparam logic [7:0] SEED_LOCKUP_FIX = 8'hFF;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] m);
    return {s[6:0], ^(s & m)};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending request
// at or after the pointer, returned both one-hot and as an index.
module rr_arbiter
  import prbs_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan from the farthest slot back to the pointer so the nearest pending one wins.
  always_comb begin
    logic [IW-1:0] w_j;
    w_j     = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j   = IW'((int'(i_ptr) + k) % N);
      o_idx = i_req[w_j] ? w_j : o_idx;
      o_any = o_any | i_req[w_j];
    end
    o_grant = o_any ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/prbs_burst_ctrl.sv
// prbs_burst_ctrl: one shared 8-bit Fibonacci LFSR serving NREQ requesters in
// round-robin bursts. Define PRBS_CTRL_RESUME_EN to resume each requester's sequence.
module prbs_burst_ctrl
  import prbs_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int BURST_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [8*NREQ-1:0]          seed,
  input  logic [POLY_SEL_W*NREQ-1:0] poly_sel,
  output logic [NREQ-1:0]            grant,
  output logic [NREQ-1:0]            done,
  output logic [7:0]                 out_byte,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int               IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NREQ - 1);
  localparam logic [7:0]       LAST_BYTE = 8'(BURST_BYTES - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_win;
  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_done;
  logic [7:0]       r_lfsr;
  logic [7:0]       r_mask;
  logic [7:0]       r_asm;
  logic [7:0]       r_out_byte;
  logic             r_out_valid;
  logic             r_busy;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_byte_cnt;

  logic [NREQ-1:0]       w_arb_grant;
  logic [IDX_W-1:0]      w_arb_idx;
  logic                  w_arb_any;
  logic [7:0]            w_seed_arr [NREQ];
  logic [POLY_SEL_W-1:0] w_psel_arr [NREQ];
  logic [7:0]            w_seed;
  logic [7:0]            w_seed_fix;
  logic [POLY_SEL_W-1:0] w_psel;
  logic [7:0]            w_load_val;
  logic                  w_stall;
  logic                  w_handshake;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDX_W)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign w_seed_arr[g] = seed[8*g +: 8];
    assign w_psel_arr[g] = poly_sel[POLY_SEL_W*g +: POLY_SEL_W];
  end

  assign w_seed      = w_seed_arr[r_win];
  assign w_psel      = w_psel_arr[r_win];
  assign w_seed_fix  = (w_seed == 8'h00) ? SEED_LOCKUP_FIX : w_seed;
  assign w_handshake = r_out_valid & out_ready;
  // Only a finished byte that cannot be handed over freezes the generator.
  assign w_stall     = (r_bit_cnt == 3'd7) & r_out_valid & ~out_ready;

`ifdef PRBS_CTRL_RESUME_EN
  logic [7:0]      r_store [NREQ];
  logic [NREQ-1:0] r_used;

  // Save the finishing requester's LFSR state so its next grant continues it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) r_store[i] <= SEED_LOCKUP_FIX;
      r_used <= '0;
    end else if (r_state == DONE) begin
      r_store[r_win] <= r_lfsr;
      r_used[r_win]  <= 1'b1;
    end
  end

  assign w_load_val = r_used[r_win] ? r_store[r_win] : w_seed_fix;
`else
  assign w_load_val = w_seed_fix;
`endif

  // Arbitration, burst sequencing, LFSR stepping and byte assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_lfsr      <= SEED_LOCKUP_FIX;
      r_mask      <= TAP_MASK[0];
      r_asm       <= 8'h00;
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= 8'd0;
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_arb_any) begin
            r_grant <= w_arb_grant;
            r_win   <= w_arb_idx;
            r_ptr   <= (w_arb_idx == LAST_IDX) ? '0 : w_arb_idx + IDX_W'(1);
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_lfsr     <= w_load_val;
          r_mask     <= TAP_MASK[w_psel];
          r_asm      <= 8'h00;
          r_bit_cnt  <= 3'd0;
          r_byte_cnt <= 8'd0;
          r_state    <= RUN;
        end
        RUN: begin
          if (!w_stall) begin
            r_lfsr    <= lfsr_step(r_lfsr, r_mask);
            r_asm     <= {r_asm[6:0], r_lfsr[7]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_out_byte  <= {r_asm[6:0], r_lfsr[7]};
              r_out_valid <= 1'b1;
              r_byte_cnt  <= r_byte_cnt + 8'd1;
              if (r_byte_cnt == LAST_BYTE) r_state <= DRAIN;
            end else if (w_handshake) begin
              r_out_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_done      <= r_grant;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_grant     <= '0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign out_byte  = r_out_byte;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// tb_prbs_burst_ctrl: directed self-checking bench for prbs_burst_ctrl
// (NREQ=4, BURST_BYTES=4); follows PRBS_CTRL_RESUME_EN when defined.
module tb_prbs_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] seed;
  logic [7:0]  poly_sel;
  logic        out_ready;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  m_state;
  logic [7:0]  cap [4];
  logic [7:0]  tb_mask [4] = '{8'hB8, 8'hB4, 8'hB2, 8'hE1};

  prbs_burst_ctrl #(
    .NREQ        (4),
    .BURST_BYTES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .seed      (seed),
    .poly_sel  (poly_sel),
    .grant     (grant),
    .done      (done),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit hit, got no summary, expected finish");
    $fatal(1, "watchdog");
  end

  // Reference: emit 8 bits MSB-first from m_state, stepping the LFSR each bit.
  task automatic model_byte(input logic [7:0] mask, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b       = {b[6:0], m_state[7]};
      m_state = {m_state[6:0], ^(m_state & mask)};
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant(input logic [3:0] exp_g, output int lat);
    int cyc;
    cyc = 0;
    while (grant === 4'b0000 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    lat = cyc;
    checks++;
    if (grant !== exp_g) begin
      errors++;
      $display("FAIL grant: got %b, expected %b", grant, exp_g);
    end
  endtask

  // Collect one burst, compare every byte to the model, then check the done pulse.
  task automatic collect(input logic [3:0] exp_g, input logic [7:0] mask,
                         input int stall_cycles, output int first_lat);
    logic [7:0] exp_b;
    logic [7:0] held;
    int n;
    int cyc;
    n = 0; cyc = 0; first_lat = -1;
    out_ready = 1'b1;
    while (n < 4 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        model_byte(mask, exp_b);
        cap[n] = out_byte;
        checks++;
        if (out_byte !== exp_b || grant !== exp_g) begin
          errors++;
          $display("FAIL burst_byte%0d: got byte %h grant %b, expected byte %h grant %b",
                   n, out_byte, grant, exp_b, exp_g);
        end
        if (n == 0) first_lat = cyc;
        n++;
        if (n == 1 && stall_cycles > 0) begin
          held = out_byte;
          out_ready = 1'b0;
          for (int s = 0; s < stall_cycles; s++) begin
            @(posedge clk); #1;
            checks++;
            if (out_byte !== held || out_valid !== 1'b1) begin
              errors++;
              $display("FAIL stall_hold: got byte %h valid %b, expected byte %h valid 1",
                       out_byte, out_valid, held);
            end
          end
          out_ready = 1'b1;
        end
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL burst_count: got %0d bytes, expected 4", n);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== exp_g) begin
      errors++;
      $display("FAIL done_pulse: got %b, expected %b", done, exp_g);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_clear: got done %b grant %b busy %b, expected 0000 0000 0",
               done, grant, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (grant !== 4'b0000 || done !== 4'b0000 || out_byte !== 8'h00 ||
        out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: got grant %b done %b byte %h valid %b busy %b, expected all 0",
               grant, done, out_byte, out_valid, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0000) begin
      errors++;
      $display("FAIL idle_no_req: got busy %b grant %b, expected 0 0000", busy, grant);
    end
  endtask

  task automatic test_single();
    int lat;
    int first_lat;
    do_reset();
    seed = 32'h0000_00FF; poly_sel = 8'h00; req = 4'b0001;
    wait_grant(4'b0001, lat);
    req = 4'b0000;
    checks++;
    if (lat != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL grant_latency: got %0d cycles busy %b, expected 1 cycle busy 1", lat, busy);
    end
    m_state = 8'hFF;
    collect(4'b0001, 8'hB8, 0, first_lat);
    checks++;
    if (first_lat != 9) begin
      errors++;
      $display("FAIL first_byte_latency: got %0d cycles after grant, expected 9", first_lat);
    end
    checks++;
    if (cap[0] !== 8'hFF || cap[1] !== 8'h0B) begin
      errors++;
      $display("FAIL hand_bytes: got %h %h, expected ff 0b", cap[0], cap[1]);
    end
  endtask

  task automatic test_round_robin();
    int lat;
    int who;
    logic [3:0] exp_g;
    do_reset();
    seed = 32'hC35A_8101; poly_sel = 8'b11_10_01_00; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      who   = k % 4;
      exp_g = 4'b0001 << who;
      wait_grant(exp_g, lat);
      if (k == 4) req = 4'b0000;
      m_state = seed[8*who +: 8];
      collect(exp_g, tb_mask[who], 0, lat);
    end
  endtask

  task automatic test_seed_zero();
    int lat;
    do_reset();
    seed = 32'h1100_2233; poly_sel = 8'b00_01_00_00; req = 4'b0100;
    wait_grant(4'b0100, lat);
    req = 4'b0000;
    m_state = 8'hFF;
    collect(4'b0100, 8'hB4, 0, lat);
  endtask

  task automatic test_stall();
    int lat;
    do_reset();
    seed = 32'h9C00_0000; poly_sel = 8'b10_00_00_00; req = 4'b1000;
    wait_grant(4'b1000, lat);
    req = 4'b0000;
    m_state = 8'h9C;
    collect(4'b1000, 8'hB2, 20, lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    int n;
    int cyc;
    do_reset();
    seed = 32'h0000_005A; poly_sel = 8'b00_00_00_11; req = 4'b0001;
    wait_grant(4'b0001, lat);
    out_ready = 1'b1;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) n++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || done !== 4'b0000 || out_byte !== 8'h00 ||
        out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midburst_reset: got grant %b done %b byte %h valid %b busy %b, expected all 0",
               grant, done, out_byte, out_valid, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (done !== 4'b0000) begin
      errors++;
      $display("FAIL no_done_after_reset: got %b, expected 0000", done);
    end
    wait_grant(4'b0001, lat);
    req = 4'b0000;
    m_state = 8'h5A;
    collect(4'b0001, 8'hE1, 0, lat);
  endtask

  task automatic test_resume();
    int lat;
    do_reset();
    seed = 32'h0000_3C00; poly_sel = 8'b00_00_01_00; req = 4'b0010;
    wait_grant(4'b0010, lat);
    m_state = 8'h3C;
    collect(4'b0010, 8'hB4, 0, lat);
    wait_grant(4'b0010, lat);
    req = 4'b0000;
`ifndef PRBS_CTRL_RESUME_EN
    m_state = 8'h3C;
`endif
    collect(4'b0010, 8'hB4, 0, lat);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; seed = 32'h0; poly_sel = 8'h00; out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_seed_zero();
    test_stall();
    test_reset_mid();
    test_resume();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
